// File: rtl/iob_uart_tb_hub.sv
// iob_uart_tb_hub: N_CH-channel 8N1 UART endpoint on an IOb slave port; define IOB_UART_TB_HUB_FLOW_EN for rts/cts flow control
module iob_uart_tb_hub #(
  parameter int          N_CH    = 2,
  parameter int          FIFO_W  = 4,
  parameter logic [15:0] DIV_RST = 16'd100,
  parameter int          ADDR_W  = 5,
  parameter int          DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic [N_CH-1:0]   txd,
  input  logic [N_CH-1:0]   rxd,
  output logic [N_CH-1:0]   rts,
  input  logic [N_CH-1:0]   cts
);
  localparam int CH_W  = ADDR_W - 2;
  localparam int DEPTH = 1 << FIFO_W;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;
  logic [CH_W-1:0]   ch;
  logic [1:0]        rsel;
  logic              wr;
  logic [DATA_W-1:0] rd_val [N_CH];
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              ready_q;
  logic              unused_ok;
  assign ch    = address[ADDR_W-1:2];
  assign rsel  = address[1:0];
  assign wr    = |wstrb;
  assign rdata = rdata_q;
  assign ready = ready_q;
`ifdef IOB_UART_TB_HUB_FLOW_EN
  assign unused_ok = ^wdata[DATA_W-1:16];
`else
  assign unused_ok = ^{wdata[DATA_W-1:16], cts};
`endif
  // Read mux: out-of-range channels and writes return zero
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < N_CH; i++) rdata_d = (!wr && ch == CH_W'(i)) ? rd_val[i] : rdata_d;
  end
  // Registered one-cycle acknowledge and read data
  always_ff @(posedge clk) begin
    ready_q <= rst ? 1'b0 : valid;
    rdata_q <= rst ? '0 : valid ? rdata_d : rdata_q;
  end
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic              sel, wr_div, wr_tx, rd_st, rd_rx, wr_ctl, flush;
    logic [15:0]       div_q;
    logic              tx_en_q, rx_en_q, ovr_q, fe_q, rts_q;
    logic [1:0]        tx_st_q, rx_st_q;
    logic [15:0]       tx_cnt_q, rx_cnt_q;
    logic [2:0]        tx_bit_q, rx_bit_q;
    logic [7:0]        tx_sh_q, hold_q, rx_sh_q;
    logic              hold_full_q;
    logic              tx_tick, tx_go, cts_ok;
    logic [2:0]        rx_s_q;
    logic              rx_in, rx_fall, rx_half, rx_tick, rx_done;
    logic              full, pop, push, ovr_set, fe_set;
    logic [7:0]        mem_q [DEPTH];
    logic [FIFO_W-1:0] wp_q, rp_q;
    logic [FIFO_W:0]   lvl_q;
    logic [7:0]        head;
    logic [15:0]       status;
    assign sel     = valid && ch == CH_W'(g);
    assign wr_div  = sel && wr && rsel == 2'd0;
    assign wr_tx   = sel && wr && rsel == 2'd1;
    assign rd_st   = sel && !wr && rsel == 2'd1;
    assign rd_rx   = sel && !wr && rsel == 2'd2;
    assign wr_ctl  = sel && wr && rsel == 2'd3;
    assign flush   = wr_ctl && wdata[2];
`ifdef IOB_UART_TB_HUB_FLOW_EN
    logic [1:0] cts_s_q;
    // Two-flop synchronizer for the peer's cts
    always_ff @(posedge clk) cts_s_q <= rst ? 2'b00 : {cts_s_q[0], cts[g]};
    assign cts_ok = cts_s_q[1];
`else
    assign cts_ok = 1'b1;
`endif
    assign tx_tick = tx_cnt_q >= div_q - 16'd1;
    assign tx_go   = tx_st_q == S_IDLE && hold_full_q && tx_en_q && cts_ok;
    assign txd[g]  = tx_st_q == S_START ? 1'b0 : tx_st_q == S_DATA ? tx_sh_q[0] : 1'b1;
    // TX holding register and frame sequencer; tx_en only gates the start of a frame
    always_ff @(posedge clk) begin
      if (rst) begin
        tx_st_q     <= S_IDLE;
        tx_cnt_q    <= '0;
        tx_bit_q    <= '0;
        tx_sh_q     <= '0;
        hold_q      <= '0;
        hold_full_q <= 1'b0;
      end else begin
        if (wr_tx && !hold_full_q) begin
          hold_q      <= wdata[7:0];
          hold_full_q <= 1'b1;
        end else if (tx_go) hold_full_q <= 1'b0;
        if (tx_go) begin
          tx_st_q  <= S_START;
          tx_cnt_q <= '0;
          tx_sh_q  <= hold_q;
        end else if (tx_st_q != S_IDLE && tx_tick) begin
          tx_cnt_q <= '0;
          tx_st_q  <= tx_st_q == S_START ? S_DATA : tx_st_q == S_STOP ? S_IDLE :
                      tx_bit_q == 3'd7 ? S_STOP : S_DATA;
          tx_bit_q <= tx_st_q == S_DATA ? tx_bit_q + 3'd1 : 3'd0;
          tx_sh_q  <= tx_st_q == S_DATA ? tx_sh_q >> 1 : tx_sh_q;
        end else if (tx_st_q != S_IDLE) tx_cnt_q <= tx_cnt_q + 16'd1;
      end
    end
    assign rx_in   = rx_s_q[1];
    assign rx_fall = rx_s_q[2] && !rx_s_q[1];
    assign rx_half = rx_cnt_q >= (div_q >> 1) - 16'd1;
    assign rx_tick = rx_cnt_q >= div_q - 16'd1;
    assign rx_done = rx_st_q == S_STOP && rx_tick;
    assign full    = lvl_q == (FIFO_W+1)'(DEPTH);
    assign pop     = rd_rx && lvl_q != '0;
    assign fe_set  = rx_done && !rx_in;
    assign push    = rx_done && rx_in && (!full || pop) && !flush;
    assign ovr_set = rx_done && rx_in && full && !pop;
    // rxd synchronizer (two flops) plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) rx_s_q <= rst ? 3'b111 : {rx_s_q[1:0], rxd[g]};
    // RX frame sequencer: mid-bit sampling, false-start rejection after half a bit
    always_ff @(posedge clk) begin
      if (rst) begin
        rx_st_q  <= S_IDLE;
        rx_cnt_q <= '0;
        rx_bit_q <= '0;
        rx_sh_q  <= '0;
      end else if (rx_st_q == S_IDLE) begin
        rx_cnt_q <= '0;
        rx_st_q  <= rx_fall && rx_en_q ? S_START : S_IDLE;
      end else if (rx_st_q == S_START) begin
        rx_cnt_q <= rx_half ? 16'd0 : rx_cnt_q + 16'd1;
        rx_st_q  <= !rx_half ? S_START : rx_in ? S_IDLE : S_DATA;
        rx_bit_q <= '0;
      end else begin
        rx_cnt_q <= rx_tick ? 16'd0 : rx_cnt_q + 16'd1;
        if (rx_tick && rx_st_q == S_DATA) begin
          rx_sh_q  <= {rx_in, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 3'd1;
          rx_st_q  <= rx_bit_q == 3'd7 ? S_STOP : S_DATA;
        end else if (rx_tick) rx_st_q <= S_IDLE;
      end
    end
    // RX FIFO storage
    always_ff @(posedge clk) if (push) mem_q[wp_q] <= rx_sh_q;
    // RX FIFO pointers and level; flush and reset empty it
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        wp_q  <= '0;
        rp_q  <= '0;
        lvl_q <= '0;
      end else begin
        wp_q  <= push ? wp_q + 1'b1 : wp_q;
        rp_q  <= pop ? rp_q + 1'b1 : rp_q;
        lvl_q <= lvl_q + (FIFO_W+1)'(push) - (FIFO_W+1)'(pop);
      end
    end
    // Divisor, control bits, sticky flags (set beats clear) and rts
    always_ff @(posedge clk) begin
      if (rst) begin
        div_q   <= DIV_RST;
        tx_en_q <= 1'b1;
        rx_en_q <= 1'b1;
        ovr_q   <= 1'b0;
        fe_q    <= 1'b0;
        rts_q   <= 1'b0;
      end else begin
        div_q   <= !wr_div ? div_q : wdata[15:0] < 16'd4 ? 16'd4 : wdata[15:0];
        tx_en_q <= wr_ctl ? wdata[0] : tx_en_q;
        rx_en_q <= wr_ctl ? wdata[1] : rx_en_q;
        ovr_q   <= ovr_set || (ovr_q && !(rd_st || flush));
        fe_q    <= fe_set || (fe_q && !(rd_st || flush));
`ifdef IOB_UART_TB_HUB_FLOW_EN
        rts_q   <= lvl_q < (FIFO_W+1)'(DEPTH - 1);
`else
        rts_q   <= 1'b1;
`endif
      end
    end
    assign rts[g]    = rts_q;
    assign head      = lvl_q != '0 ? mem_q[rp_q] : 8'd0;
    assign status    = {8'(lvl_q), 2'b00, fe_q, ovr_q, full, lvl_q != '0, hold_full_q, tx_st_q != S_IDLE};
    assign rd_val[g] = rsel == 2'd0 ? DATA_W'(div_q) : rsel == 2'd1 ? DATA_W'(status) :
                       rsel == 2'd2 ? DATA_W'(head) : DATA_W'({rx_en_q, tx_en_q});
  end
endmodule

// File: tb/tb_iob_uart_tb_hub.sv
// tb_iob_uart_tb_hub: directed/randomized bench for iob_uart_tb_hub with a queue-based UART model
module tb_iob_uart_tb_hub;
  logic        clk = 1'b0, rst = 1'b1, valid = 1'b0, loop = 1'b0;
  logic [4:0]  address = '0;
  logic [31:0] wdata = '0, rdata, r;
  logic [3:0]  wstrb = '0;
  logic        ready;
  logic [1:0]  txd, rxd, rts, cts = 2'b11, rxd_drv = 2'b11;
  logic [7:0]  mq0[$], mq1[$];
  bit          fe[2], ovr[2];
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign rxd = {loop ? txd[0] : rxd_drv[1], rxd_drv[0]};
  iob_uart_tb_hub #(.N_CH(2), .FIFO_W(4), .DIV_RST(16'd100), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .txd(txd), .rxd(rxd), .rts(rts), .cts(cts));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic bus(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] q);
    @(negedge clk);
    valid = 1'b1; address = a; wdata = d; wstrb = s;
    @(negedge clk);
    valid = 1'b0; wstrb = '0; q = rdata;
    chk("ready", {31'd0, ready}, 32'd1);
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus(a, d, 4'hf, q);
  endtask
  task automatic rd_chk(input logic [4:0] a, input string tag, input logic [31:0] exp);
    logic [31:0] q;
    bus(a, 32'd0, 4'h0, q);
    chk(tag, q, exp);
  endtask
  function automatic logic [31:0] st_exp(input int c);
    int n = c != 0 ? mq1.size() : mq0.size();
    return {16'd0, 8'(n), 2'b00, fe[c], ovr[c], n == 16, n != 0, 2'b00};
  endfunction
  task automatic m_rx(input int c, input logic [7:0] b, input bit stop);
    int n = c != 0 ? mq1.size() : mq0.size();
    if (!stop) fe[c] = 1'b1;
    else if (n == 16) ovr[c] = 1'b1;
    else if (c != 0) mq1.push_back(b);
    else mq0.push_back(b);
  endtask
  task automatic chk_status(input int c, input string tag);
    rd_chk(5'(c * 4 + 1), tag, st_exp(c));
    fe[c] = 1'b0; ovr[c] = 1'b0;
  endtask
  task automatic chk_pop(input int c, input string tag);
    logic [7:0] e = 8'd0;
    if (c != 0 && mq1.size() != 0) e = mq1.pop_front();
    if (c == 0 && mq0.size() != 0) e = mq0.pop_front();
    rd_chk(5'(c * 4 + 2), tag, {24'd0, e});
  endtask
  task automatic send(input int c, input logic [7:0] b, input bit stop, input int div);
    @(negedge clk);
    rxd_drv[c] = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv[c] = b[i];
      repeat (div) @(negedge clk);
    end
    rxd_drv[c] = stop;
    repeat (div) @(negedge clk);
    rxd_drv[c] = 1'b1;
    repeat (div) @(negedge clk);
  endtask
  task automatic tx_chk(input logic [7:0] b, input int div);
    logic [7:0] got = '0;
    wr(5'd1, {24'd0, b});
    chk("tx_pre_start", {31'd0, txd[0]}, 32'd1);
    @(negedge clk);
    chk("tx_start", {31'd0, txd[0]}, 32'd0);
    repeat (div / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (div) @(negedge clk);
      got[i] = txd[0];
    end
    repeat (div) @(negedge clk);
    chk("tx_stop", {31'd0, txd[0]}, 32'd1);
    chk("tx_byte", {24'd0, got}, {24'd0, b});
    repeat (div) @(negedge clk);
  endtask
  initial begin
    logic [7:0] b;
    int c, n;
    bit bad;
    repeat (3) @(negedge clk);
    chk("rst_txd", {30'd0, txd}, 32'd3);
    chk("rst_rts", {30'd0, rts}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rts_after_rst", {30'd0, rts}, 32'd3);
    rd_chk(5'd1, "st0_rst", 32'd0);
    rd_chk(5'd4, "div1_rst", 32'd100);
    rd_chk(5'd3, "ctrl0_rst", 32'd3);
    wr(5'd4, 32'd2);
    rd_chk(5'd4, "div_clamp", 32'd4);
    wr(5'd0, 32'd8);
    wr(5'd4, 32'd8);
    loop = 1'b1;
    wr(5'd1, 32'hA5);
    rd_chk(5'd1, "st0_busy", 32'd1);
    repeat (86) @(negedge clk);
    loop = 1'b0;
    mq1.push_back(8'hA5);
    chk_pop(1, "loop_rx");
    chk_status(1, "loop_st");
    wr(5'd20, 32'd123);
    rd_chk(5'd20, "oor_div", 32'd0);
    wr(5'd21, 32'h55);
    rd_chk(5'd21, "oor_st", 32'd0);
`ifndef IOB_UART_TB_HUB_FLOW_EN
    cts = 2'b00;
`endif
    for (int i = 0; i < 3; i++) tx_chk(8'($urandom), 8);
    cts = 2'b11;
    for (int i = 0; i < 17; i++) begin
      send(0, 8'(i), 1'b1, 8);
      m_rx(0, 8'(i), 1'b1);
`ifdef IOB_UART_TB_HUB_FLOW_EN
      if (i == 13) chk("rts_14", {31'd0, rts[0]}, 32'd1);
      if (i == 14) chk("rts_15", {31'd0, rts[0]}, 32'd0);
`else
      if (i == 14) chk("rts_tied", {31'd0, rts[0]}, 32'd1);
`endif
    end
    chk_status(0, "ovr_st");
    for (int i = 0; i < 16; i++) chk_pop(0, "ovr_pop");
    chk_status(0, "ovr_clr");
    chk_pop(0, "empty_pop");
    b = 8'($urandom);
    send(0, b, 1'b0, 8);
    m_rx(0, b, 1'b0);
    chk_status(0, "fe_st");
    chk_status(0, "fe_clr");
    wr(5'd0, 32'd16);
    @(negedge clk);
    rxd_drv[0] = 1'b0;
    repeat (2) @(negedge clk);
    rxd_drv[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk_status(0, "glitch");
    for (int i = 0; i < 6; i++) begin
      c = int'($urandom_range(0, 1));
      b = 8'($urandom);
      send(c, b, 1'b1, c != 0 ? 8 : 16);
      m_rx(c, b, 1'b1);
    end
    chk_status(0, "rnd_st0");
    chk_status(1, "rnd_st1");
    n = mq0.size();
    for (int i = 0; i <= n; i++) chk_pop(0, "rnd_pop0");
    n = mq1.size();
    for (int i = 0; i <= n; i++) chk_pop(1, "rnd_pop1");
    wr(5'd7, 32'd1);
    send(1, 8'($urandom), 1'b1, 8);
    chk_status(1, "rx_dis");
    wr(5'd7, 32'd3);
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      send(1, b, 1'b1, 8);
      m_rx(1, b, 1'b1);
    end
    chk_status(1, "pre_flush");
    wr(5'd7, 32'd7);
    mq1.delete();
    chk_status(1, "flush");
    rd_chk(5'd7, "ctrl_flush", 32'd3);
`ifdef IOB_UART_TB_HUB_FLOW_EN
    cts[0] = 1'b0;
    repeat (4) @(negedge clk);
    wr(5'd1, 32'h3C);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txd[0] !== 1'b1) bad = 1'b1;
    end
    chk("cts_hold_txd", {31'd0, bad}, 32'd0);
    rd_chk(5'd1, "cts_hold_st", 32'd2);
    cts[0] = 1'b1;
    n = 0;
    while (txd[0] === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("cts_start", {31'd0, n <= 4}, 32'd1);
    repeat (170) @(negedge clk);
`endif
    wr(5'd1, {24'd0, 8'($urandom)});
    wr(5'd1, {24'd0, 8'($urandom)});
    repeat (20) @(negedge clk);
    rd_chk(5'd1, "mid_tx_st", 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_txd", {30'd0, txd}, 32'd3);
    rst = 1'b0;
    rd_chk(5'd1, "rst_mid_st", 32'd0);
    rd_chk(5'd0, "rst_mid_div", 32'd100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iob_uart_tb_hub.md
# iob_uart_tb_hub

Parametrised multi-channel UART endpoint for simulation top-levels. It replaces the single hand-wired testbench UART with N_CH independent 8N1 channels. Each channel has a programmable bit divisor, a single-byte TX holding register, an RX FIFO, sticky error flags and rts/cts flow control. The testbench drives it over one IOb native slave port, and its serial pins attach crosswise to the unit-under-test UART pins (txd→rxd, rts→cts).

## Interface
Parameters:
- N_CH, 2: number of UART channels (1..8).
- FIFO_W, 4: log2 of RX FIFO depth per channel (depth 16).
- DIV_RST, 16'd100: reset value of every channel's divisor.
- ADDR_W, 5: word-address width; must satisfy ADDR_W ≥ 2 + clog2(N_CH).
- DATA_W, 32: CPU data width.

Ports (reset is synchronous, active-high; single clock domain):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- valid  in  1  request strobe.
- address  in  ADDR_W  word address: [1:0] register, [ADDR_W-1:2] channel.
- wdata  in  DATA_W  write data.
- wstrb  in  4  byte enables; 0 = read.
- rdata  out  DATA_W  read data, valid with ready.
- ready  out  1  one-cycle acknowledge.
- txd  out  N_CH  serial out per channel, idle high.
- rxd  in  N_CH  serial in per channel, asynchronous.
- rts  out  N_CH  high = channel can accept RX data.
- cts  in  N_CH  high = peer can accept TX data.

## Operation
Registers per channel:
- 0 DIV (RW, [15:0]). Bit period in clk cycles. Writes below 4 are clamped to 4.
- 1 TXDATA/STATUS.
  - Write: loads the holding register with wdata[7:0]. Ignored if the holding register is already full.
  - Read: STATUS = {[15:8] rx_level, [5] frame_err, [4] overrun, [3] rx_full, [2] rx_nonempty, [1] tx_hold_full, [0] tx_busy}.
  - Reading STATUS clears overrun and frame_err. A set event in the same cycle wins over the clear.
- 2 RXDATA (RO). Returns the FIFO head in [7:0] and pops it. When empty, returns 0 with no pop.
- 3 CTRL (RW).
  - [0] tx_en, reset 1.
  - [1] rx_en, reset 1.
  - [2] flush, self-clearing: empties the RX FIFO and clears the sticky flags.
- Channel index ≥ N_CH: reads return 0, writes are ignored, and ready is still returned.

TX FSM per channel (IDLE, START, DATA, STOP):
- IDLE → START when hold_full & tx_en & cts_ok. The holding register moves to the shift register and hold_full clears.
- START, DATA (8 bits, LSB first) and STOP each last DIV cycles. STOP → IDLE.
- tx_busy is high in every state except IDLE.
- Clearing tx_en mid-frame completes the current frame.

RX FSM per channel (IDLE, START, DATA, STOP):
- rxd passes through a 2-FF synchronizer.
- IDLE → START on a synchronized falling edge, only when rx_en = 1.
- START: waits DIV/2 cycles, then re-samples. If the line is high (false start), return to IDLE.
- DATA: samples 8 bits at DIV-cycle intervals.
- STOP: samples after DIV cycles.
  - Stop bit low: set frame_err and discard the byte.
  - FIFO full: set overrun and discard the byte.
  - Otherwise push the byte.
- Returns to IDLE immediately after the stop sample.

Other rules:
- Changing DIV mid-frame takes effect at the next bit boundary. The testbench must not do this.
- FIFO: push and pop in the same cycle on a non-empty FIFO leaves the level unchanged. Full-state push/pop is likewise allowed when the pop is first.
- rst returns every FSM to IDLE, aborts frames in flight, and empties all FIFOs.

## Timing
- ready is high exactly 1 cycle after a cycle with valid = 1. rdata is registered and valid in that cycle.
- valid is single-cycle. A new request is legal in the cycle ready is high.
- Reset values:
  - txd = all ones, rts = 0, ready = 0, rdata = 0.
  - DIV = DIV_RST, CTRL = 3'b011.
  - All sticky flags and holding registers are empty/zero.
- A TXDATA write at cycle t with cts_ok starts the start bit at t+2. The txd frame lasts 10·DIV cycles.
- RX byte visible in rx_level: 3 cycles after the stop-bit sample point (2 synchronizer + 1 push).
- rts is registered: rts = (rx_level < 2^FIFO_W − 1), so one slot of slack is kept.

## Configuration
- IOB_UART_TB_HUB_FLOW_EN defined:
  - cts is synchronized (2-FF) and sampled only in TX IDLE (cts_ok = synchronized cts).
  - rts is driven as described above.
- Not defined:
  - cts_ok = 1 and the cts input is ignored.
  - rts is tied to 1 after reset (0 during reset).

## Test plan
- Reset, then read STATUS ch0 and DIV ch1 → 0x00000000 and 100. txd = all ones. rts = all ones 1 cycle after rst falls.
- DIV ch0 = 8, write TXDATA 0xA5, txd0 looped to rxd1, DIV ch1 = 8 → ch1 RXDATA = 0xA5 within 90 cycles. STATUS ch1 = 0 after the pop.
- Inject 17 bytes 0x00..0x10 on rxd0 without reading:
  - STATUS overrun = 1 and rx_level = 16.
  - rts0 low after the 15th byte (FLOW_EN build).
  - Reading all 16 returns 0x00..0x0F.
  - Next STATUS read has overrun = 0.
- Inject a frame with stop bit 0 → frame_err = 1 and rx_level = 0. A 2-cycle low glitch on rxd (DIV = 16) → no byte and no error.
- FLOW_EN: hold cts0 = 0 and write TXDATA 0x3C → txd0 stays high and tx_hold_full = 1. Raise cts0 → frame starts within 4 cycles.
- Assert rst mid-TX frame → txd returns high the next cycle, tx_busy = 0, and the holding register is empty.
